// File: rtl/tpu_pkg.sv
// Shared sizing defaults, feeder FSM state encoding and drain-counter width helper.
package tpu_pkg;
  localparam int DIM_DEF     = 8;
  localparam int BITS_AB_DEF = 8;

  // Width of a counter spanning 0..dim-1; a 1-lane build still gets one bit.
  function automatic int cnt_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int DRAIN_CNT_W = cnt_w(DIM_DEF);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/skew_lane.sv
// One feeder lane: DEPTH-stage data + valid delay line, advancing only while en is high.
module skew_lane #(
  parameter int DEPTH   = 1,
  parameter int BITS_AB = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [BITS_AB-1:0] din,
  input  logic               vin,
  output logic [BITS_AB-1:0] dout,
  output logic               vout
);
  logic [DEPTH-1:0][BITS_AB-1:0] dpipe;
  logic [DEPTH-1:0]              vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      dpipe    <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      dpipe[0]    <= din;
      vld_pipe[0] <= vin;
      for (int k = 1; k < DEPTH; k++) begin
        dpipe[k]    <= dpipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end
  end

  assign dout = dpipe[DEPTH-1];
  assign vout = vld_pipe[DEPTH-1];
endmodule

// File: rtl/skew_feeder.sv
// Skews matrix rows diagonally into a systolic array; lane i delays by i+1 stages.
// Optional SKEW_ROW_COUNT_EN adds a saturating rows_fed counter output.
module skew_feeder
  import tpu_pkg::*;
#(
  parameter int DIM     = DIM_DEF,
  parameter int BITS_AB = BITS_AB_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [DIM*BITS_AB-1:0] Ain,
  output logic [DIM*BITS_AB-1:0] Aout,
  output logic [DIM-1:0]         lane_valid,
  output logic                   busy,
  output logic                   done
`ifdef SKEW_ROW_COUNT_EN
  ,
  output logic [15:0]            rows_fed
`endif
);
  localparam int CW = cnt_w(DIM);

  state_t                        state;
  logic [CW-1:0]                 drain_cnt;
  logic                          accept;
  logic [DIM-1:0][BITS_AB-1:0]   lane_out;

  assign in_ready = en && (state == S_IDLE || state == S_STREAM);
  assign accept   = in_valid && in_ready;

  // DRAIN waits DIM-1 advancing edges so done lines up with the last element on lane DIM-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_STREAM: if (accept) begin
          if (!in_last) begin
            state <= S_STREAM;
            busy  <= 1'b1;
          end else if (DIM == 1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_DRAIN;
            busy  <= 1'b1;
          end
        end
        S_DRAIN: if (en) begin
          if (drain_cnt == CW'(DIM - 2)) begin
            state     <= S_DONE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SKEW_ROW_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_DONE)
      rows_fed <= '0;
    else if (accept && rows_fed != 16'hFFFF)
      rows_fed <= rows_fed + 16'd1;
  end
`endif

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_lane #(
      .DEPTH  (i + 1),
      .BITS_AB(BITS_AB)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .din (accept ? Ain[i*BITS_AB +: BITS_AB] : {BITS_AB{1'b0}}),
      .vin (accept),
      .dout(lane_out[i]),
      .vout(lane_valid[i])
    );
  end

  assign Aout = lane_out;
endmodule

// File: tb/tb_skew_feeder.sv
// Directed table-driven bench for skew_feeder at DIM=4, BITS_AB=8.
module tb_skew_feeder;
  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_last;
  logic        in_ready, busy, done;
  logic [31:0] Ain, Aout;
  logic [3:0]  lane_valid;
`ifdef SKEW_ROW_COUNT_EN
  logic [15:0] rows_fed;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  skew_feeder #(.DIM(4), .BITS_AB(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .Ain       (Ain),
    .Aout      (Aout),
    .lane_valid(lane_valid),
    .busy      (busy),
    .done      (done)
`ifdef SKEW_ROW_COUNT_EN
    ,
    .rows_fed  (rows_fed)
`endif
  );

  typedef struct {
    logic        rst, en, vin, last;
    logic [31:0] ain;
    logic        chk_rdy, rdy;
    logic [31:0] aout;
    logic [3:0]  vld;
    logic        busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic e, logic vi, logic l, logic [31:0] a,
                             logic cr, logic rd, logic [31:0] ao, logic [3:0] vl,
                             logic b, logic d);
    vec_t t;
    t.rst = r; t.en = e; t.vin = vi; t.last = l; t.ain = a;
    t.chk_rdy = cr; t.rdy = rd; t.aout = ao; t.vld = vl; t.busy = b; t.done = d;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  initial begin
    // Four back-to-back rows (element j of row r = 10r+j); in_valid during DRAIN/DONE ignored.
    vecs.push_back(v(0,1,1,0,32'h03020100, 1,1, 32'h00000000,4'b0001, 1,0));
    vecs.push_back(v(0,1,1,0,32'h0D0C0B0A, 1,1, 32'h0000010A,4'b0011, 1,0));
    vecs.push_back(v(0,1,1,0,32'h17161514, 1,1, 32'h00020B14,4'b0111, 1,0));
    vecs.push_back(v(0,1,1,1,32'h21201F1E, 1,1, 32'h030C151E,4'b1111, 1,0));
    vecs.push_back(v(0,1,1,0,32'hDEADBEEF, 1,0, 32'h0D161F00,4'b1110, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h17200000,4'b1100, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h21000000,4'b1000, 0,1));
    vecs.push_back(v(0,1,1,1,32'h11111111, 1,0, 32'h00000000,4'b0000, 0,0));
    // Single-row matrix {1,2,3,4}.
    vecs.push_back(v(0,1,1,1,32'h04030201, 1,1, 32'h00000001,4'b0001, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00000200,4'b0010, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00030000,4'b0100, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h04000000,4'b1000, 0,1));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00000000,4'b0000, 0,0));
    // Bubble between {5,5,5,5} and {-3,-3,-3,-3}.
    vecs.push_back(v(0,1,1,0,32'h05050505, 1,1, 32'h00000005,4'b0001, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,1, 32'h00000500,4'b0010, 1,0));
    vecs.push_back(v(0,1,1,1,32'hFDFDFDFD, 1,1, 32'h000500FD,4'b0101, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h0500FD00,4'b1010, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00FD0000,4'b0100, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'hFD000000,4'b1000, 0,1));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00000000,4'b0000, 0,0));
    // en=0 stalls mid-stream, mid-drain and in DONE (DONE still lasts one cycle).
    vecs.push_back(v(0,1,1,0,32'h03020100, 1,1, 32'h00000000,4'b0001, 1,0));
    vecs.push_back(v(0,1,1,0,32'h0D0C0B0A, 1,1, 32'h0000010A,4'b0011, 1,0));
    vecs.push_back(v(0,0,1,1,32'hAAAAAAAA, 1,0, 32'h0000010A,4'b0011, 1,0));
    vecs.push_back(v(0,0,1,1,32'hAAAAAAAA, 1,0, 32'h0000010A,4'b0011, 1,0));
    vecs.push_back(v(0,1,1,0,32'h17161514, 1,1, 32'h00020B14,4'b0111, 1,0));
    vecs.push_back(v(0,1,1,1,32'h21201F1E, 1,1, 32'h030C151E,4'b1111, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h0D161F00,4'b1110, 1,0));
    vecs.push_back(v(0,0,0,0,32'h00000000, 1,0, 32'h0D161F00,4'b1110, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h17200000,4'b1100, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h21000000,4'b1000, 0,1));
    vecs.push_back(v(0,0,0,0,32'h00000000, 1,0, 32'h21000000,4'b1000, 0,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,1, 32'h00000000,4'b0000, 0,0));
    // Reset during DRAIN: in-flight data dropped, no done pulse afterwards.
    vecs.push_back(v(0,1,1,1,32'h04030201, 1,1, 32'h00000001,4'b0001, 1,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,0, 32'h00000200,4'b0010, 1,0));
    vecs.push_back(v(1,1,0,0,32'h00000000, 1,0, 32'h00000000,4'b0000, 0,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,1, 32'h00000000,4'b0000, 0,0));
    vecs.push_back(v(0,1,0,0,32'h00000000, 1,1, 32'h00000000,4'b0000, 0,0));

    // Reset held two cycles with a pending row; reset must win.
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_last = 1'b1; Ain = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aout", -1, Aout, 32'h0);
    chk("rst_vld", -1, {28'h0, lane_valid}, 32'h0);
    chk("rst_busy", -1, {31'h0, busy}, 32'h0);
    chk("rst_done", -1, {31'h0, done}, 32'h0);
`ifdef SKEW_ROW_COUNT_EN
    chk("rst_rows", -1, {16'h0, rows_fed}, 32'h0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; in_valid = vecs[i].vin;
      in_last = vecs[i].last; Ain = vecs[i].ain;
      #1;
      if (vecs[i].chk_rdy) chk("in_ready", i, {31'h0, in_ready}, {31'h0, vecs[i].rdy});
      @(posedge clk);
      #1;
      chk("aout", i, Aout, vecs[i].aout);
      chk("lane_valid", i, {28'h0, lane_valid}, {28'h0, vecs[i].vld});
      chk("busy", i, {31'h0, busy}, {31'h0, vecs[i].busy});
      chk("done", i, {31'h0, done}, {31'h0, vecs[i].done});
`ifdef SKEW_ROW_COUNT_EN
      if (vecs[i].rst) chk("rows_fed", i, {16'h0, rows_fed}, 32'h0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
